// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect inputs, stall, and the instruction-memory request handshake.
// AddrError exists only when PC_ADDR_ERR_EN is defined.
interface pc_fetch_unit_if;
    logic [31:0] BranchTarget;
    logic        BranchTaken;
    logic [31:0] JumpTarget;
    logic        Jump;
    logic        Stall;
    logic        FetchReady;
    logic        FetchValid;
    logic [31:0] FetchAddr;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        RedirectPending;
`ifdef PC_ADDR_ERR_EN
    logic        AddrError;
`endif

    modport master (
`ifdef PC_ADDR_ERR_EN
        output AddrError,
`endif
        input  BranchTarget, BranchTaken, JumpTarget, Jump, Stall, FetchReady,
        output FetchValid, FetchAddr, PCResult, PCAddResult, RedirectPending
    );

    modport slave (
`ifdef PC_ADDR_ERR_EN
        input  AddrError,
`endif
        output BranchTarget, BranchTaken, JumpTarget, Jump, Stall, FetchReady,
        input  FetchValid, FetchAddr, PCResult, PCAddResult, RedirectPending
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC stage: holds the PC, issues valid/ready fetch requests, buffers redirects that arrive
// while a request is stuck. Optional misaligned-target trap via macro PC_ADDR_ERR_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    pc_fetch_unit_if.master bus
);
    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;

    logic          fetch_valid_c;
    logic          accept_c;
    logic          redir_c, redir_bad_c, redir_ok_c;
    logic [AW-1:0] redir_raw_c, redir_tgt_c, pc_inc_c;

    assign pc_inc_c      = pc_q + AW'(PC_STEP);
    assign fetch_valid_c = (state_q == ST_FETCH) && !bus.Stall;
    assign accept_c      = fetch_valid_c && bus.FetchReady;

    // Jump wins over branch; target is word-aligned by masking.
    always_comb begin
        redir_c     = bus.Jump | bus.BranchTaken;
        redir_raw_c = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
        redir_tgt_c = redir_raw_c & ~AW'(3);
`ifdef PC_ADDR_ERR_EN
        redir_bad_c = redir_c && (redir_raw_c[1:0] != 2'b00);
`else
        redir_bad_c = 1'b0;
`endif
        redir_ok_c  = redir_c && !redir_bad_c;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        case (state_q)
            ST_BOOT:  if (!bus.Stall) state_d = ST_FETCH;
            ST_FETCH: if (bus.Stall)  state_d = ST_HOLD;
            ST_HOLD:  if (!bus.Stall) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase

        // Stuck request keeps FetchAddr stable, so a redirect must wait in pending.
        if (accept_c) begin
            if (redir_ok_c)      pc_d = redir_tgt_c;
            else if (pend_vld_q) pc_d = pend_q;
            else                 pc_d = pc_inc_c;
            pend_vld_d = 1'b0;
        end else if (fetch_valid_c) begin
            if (redir_ok_c) begin
                pend_d     = redir_tgt_c;
                pend_vld_d = 1'b1;
            end
        end else if (redir_ok_c) begin
            pc_d       = redir_tgt_c;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

`ifdef PC_ADDR_ERR_EN
    logic addr_err_q, addr_err_d;

    // Sticky until reset.
    always_comb addr_err_d = addr_err_q | redir_bad_c;

    always_ff @(posedge Clk) begin
        if (!Reset) addr_err_q <= 1'b0;
        else        addr_err_q <= addr_err_d;
    end

    assign bus.AddrError = addr_err_q;
`endif

    assign bus.FetchValid      = fetch_valid_c;
    assign bus.FetchAddr       = pc_q;
    assign bus.PCResult        = pc_q;
    assign bus.PCAddResult     = pc_inc_c;
    assign bus.RedirectPending = pend_vld_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses are queued by the stimulus
// and popped by a monitor on every accepted request; directed checks cover the rest.
module tb_pc_fetch_unit;
    logic Clk = 1'b0;
    logic rst_n;
    logic rst_hi_n;

    pc_fetch_unit_if bus();
    pc_fetch_unit_if bus_hi();

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .PC_STEP(4)) u_dut (
        .Clk(Clk), .Reset(rst_n), .bus(bus)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .PC_STEP(4)) u_dut_hi (
        .Clk(Clk), .Reset(rst_hi_n), .bus(bus_hi)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic mid();
        @(negedge Clk);
    endtask

    // Monitor: every accepted request must match the head of the expected queue.
    always @(negedge Clk) begin
        if (rst_n && bus.FetchValid && bus.FetchReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_unexpected: got %h expected none", bus.FetchAddr);
            end else begin
                mon_e = exp_q.pop_front();
                check("accept_addr", bus.FetchAddr, mon_e);
                check("accept_inc", bus.PCAddResult, mon_e + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n    = 1'b0;
        rst_hi_n = 1'b0;
        bus.BranchTarget = '0; bus.BranchTaken = 1'b0;
        bus.JumpTarget   = '0; bus.Jump        = 1'b0;
        bus.Stall        = 1'b0; bus.FetchReady = 1'b1;
        bus_hi.BranchTarget = '0; bus_hi.BranchTaken = 1'b0;
        bus_hi.JumpTarget   = '0; bus_hi.Jump        = 1'b0;
        bus_hi.Stall        = 1'b0; bus_hi.FetchReady = 1'b1;

        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'h0000_0008);
        exp_q.push_back(32'h0000_000C);
        exp_q.push_back(32'h0000_0010);
        exp_q.push_back(32'h0000_0040);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0080);
        exp_q.push_back(32'h0000_0084);
`ifdef PC_ADDR_ERR_EN
        exp_q.push_back(32'h0000_0088);
`else
        exp_q.push_back(32'h0000_0040);
`endif

        nxt();
        nxt();
        mid();
        check("rst_fv", 32'(bus.FetchValid), 32'd0);
        check("rst_pc", bus.PCResult, 32'h0);
        check("rst_inc", bus.PCAddResult, 32'h4);
        check("rst_rp", 32'(bus.RedirectPending), 32'd0);
`ifdef PC_ADDR_ERR_EN
        check("rst_aerr", 32'(bus.AddrError), 32'd0);
`endif

        nxt();
        rst_n = 1'b1;
        mid();
        check("boot_fv", 32'(bus.FetchValid), 32'd0);

        nxt();  // accept 0x0
        nxt();  // accept 0x4
        nxt();
        bus.FetchReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("hold_fv", 32'(bus.FetchValid), 32'd1);
            check("hold_addr", bus.FetchAddr, 32'h8);
            nxt();
        end
        bus.FetchReady = 1'b1;  // accept 0x8
        nxt();                  // accept 0xC
        nxt();
        bus.FetchReady  = 1'b0;
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'h40;
        mid();
        check("pend_before", 32'(bus.RedirectPending), 32'd0);
        nxt();
        bus.BranchTaken = 1'b0;
        mid();
        check("pend_set", 32'(bus.RedirectPending), 32'd1);
        check("pend_addr", bus.FetchAddr, 32'h10);
        nxt();
        bus.FetchReady = 1'b1;  // accept 0x10, next is pending 0x40
        nxt();
        mid();
        check("pend_clr", 32'(bus.RedirectPending), 32'd0);
        bus.Jump = 1'b1; bus.JumpTarget = 32'h100;
        bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h200;
        nxt();
        bus.JumpTarget = 32'h20;
        bus.BranchTaken = 1'b0;
        nxt();
        bus.Jump  = 1'b0;
        bus.Stall = 1'b1;
        mid();
        check("stall1_fv", 32'(bus.FetchValid), 32'd0);
        check("stall1_pc", bus.PCResult, 32'h20);
        nxt();
        bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h80;
        mid();
        check("stall2_fv", 32'(bus.FetchValid), 32'd0);
        nxt();
        bus.Stall = 1'b0;
        bus.BranchTaken = 1'b0;
        w = 0;
        mid();
        while (!bus.FetchValid && w < 4) begin
            nxt();
            mid();
            w++;
        end
        check("unstall_fv", 32'(bus.FetchValid), 32'd1);
        check("unstall_addr", bus.FetchAddr, 32'h80);
        nxt();
        bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h43;
        nxt();
        bus.BranchTaken = 1'b0;
        mid();
`ifdef PC_ADDR_ERR_EN
        check("aerr_set", 32'(bus.AddrError), 32'd1);
`endif
        nxt();
        bus.FetchReady = 1'b0;
        mid();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        nxt();
        rst_hi_n = 1'b1;
        mid();
        check("hi_boot_fv", 32'(bus_hi.FetchValid), 32'd0);
        check("hi_boot_pc", bus_hi.PCResult, 32'hFFFF_FFFC);
        nxt();
        mid();
        check("hi_fv", 32'(bus_hi.FetchValid), 32'd1);
        check("hi_addr0", bus_hi.FetchAddr, 32'hFFFF_FFFC);
        check("hi_wrap_inc", bus_hi.PCAddResult, 32'h0);
        nxt();
        mid();
        check("hi_addr1", bus_hi.FetchAddr, 32'h0);
        check("hi_inc1", bus_hi.PCAddResult, 32'h4);
        nxt();
        rst_hi_n = 1'b0;
        nxt();
        mid();
        check("hi_rst_fv", 32'(bus_hi.FetchValid), 32'd0);
        check("hi_rst_pc", bus_hi.PCResult, 32'hFFFF_FFFC);
        check("hi_rst_inc", bus_hi.PCAddResult, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
